// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: Avalon-MM bus between the Nios II master and the I2S transmitter
interface audio_i2s_tx_if;
  logic cs;
  logic read;
  logic write;
  logic [1:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output cs, read, write, addr, writedata, input readdata);
  modport slave(input cs, read, write, addr, writedata, output readdata);
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: Avalon-MM sample FIFO serialised to an I2S DAC
module audio_i2s_tx #(
  parameter int FIFO_DEPTH = 256,
  parameter int BCLK_DIV = 16
) (
  input logic CLK,
  input logic RESET,
  audio_i2s_tx_if.slave avl,
  output logic IRQ,
  output logic I2S_BCLK,
  output logic I2S_LRCLK,
  output logic I2S_DOUT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level;
  logic [DW-1:0] div;
  logic [4:0] b, bn;
  logic [31:0] shadow, shift, rdata;
  logic en, irq_en, undr, ovf, bclk, lrclk;
  logic wr_data, wr_stat, wr_ctrl, flush, push, pop_req, pop, empty, full, tick, fall;
  assign empty = level == '0;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign wr_data = avl.cs & avl.write & (avl.addr == 2'd0);
  assign wr_stat = avl.cs & avl.write & (avl.addr == 2'd1);
  assign wr_ctrl = avl.cs & avl.write & (avl.addr == 2'd2);
  assign flush = wr_ctrl & avl.writedata[1];
  assign push = wr_data & ~full & ~flush;
  assign pop = pop_req & ~empty;
  assign tick = div == DW'(BCLK_DIV - 1);
  assign fall = tick & bclk;
  assign bn = b + 5'd1;
  assign I2S_BCLK = bclk;
  assign I2S_LRCLK = lrclk;
  assign I2S_DOUT = shift[31];
  // Read mux; DATA and the unused address read as zero
  always_comb begin
    rdata = avl.addr == 2'd1 ? {11'd0, state == RUN, ovf, undr, full, empty, 6'd0, 10'(level)} :
            avl.addr == 2'd2 ? {29'd0, irq_en, 1'b0, en} : 32'd0;
  end
  // Next state; the frame pop happens on leaving IDLE and on every entry into slot 31
  always_comb begin
    state_n = en ? RUN : IDLE;
    pop_req = en & (state == IDLE | (fall & bn == 5'd31));
  end
  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  // Bit clock divider, slot counter and shifter; held at rest whenever not running
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div <= '0;
      b <= 5'd31;
      bclk <= 1'b0;
      lrclk <= 1'b0;
      shift <= '0;
    end else if (state == IDLE || !en) begin
      div <= '0;
      b <= 5'd31;
      bclk <= 1'b0;
      lrclk <= 1'b0;
      shift <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      bclk <= tick ? ~bclk : bclk;
      if (fall) begin
        b <= bn;
        lrclk <= bn >= 5'd15 && bn <= 5'd30;
        shift <= bn == 5'd0 ? shadow : shift << 1;
      end
    end
  end
  // FIFO pointers, level and the shadow word for the next frame
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      shadow <= '0;
    end else begin
      wp <= flush ? '0 : wp + AW'(push);
      rp <= flush ? '0 : rp + AW'(pop);
      level <= flush ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop_req) shadow <= empty ? 32'd0 : mem[rp];
    end
  end
  // Sample storage
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= avl.writedata;
  end
  // Control, sticky flags, interrupt and registered read data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en <= 1'b0;
      irq_en <= 1'b0;
      undr <= 1'b0;
      ovf <= 1'b0;
      IRQ <= 1'b0;
      avl.readdata <= '0;
    end else begin
      undr <= (pop_req & empty) | (undr & ~(wr_stat & avl.writedata[18]));
      ovf <= (wr_data & full) | (ovf & ~(wr_stat & avl.writedata[19]));
      en <= wr_ctrl ? avl.writedata[0] : en;
      irq_en <= wr_ctrl ? avl.writedata[2] : irq_en;
      IRQ <= irq_en & (level < (AW+1)'(FIFO_DEPTH / 2));
      avl.readdata <= avl.cs & avl.read ? rdata : 32'd0;
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized check of the I2S transmitter against a frame-level model
module tb_audio_i2s_tx;
  logic clk = 0, rst = 1;
  logic irq, bclk, lrclk, dout;
  audio_i2s_tx_if avl();
  audio_i2s_tx dut(.CLK(clk), .RESET(rst), .avl(avl), .IRQ(irq), .I2S_BCLK(bclk), .I2S_LRCLK(lrclk), .I2S_DOUT(dout));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  bit mon = 0;
  int per, nfr, hi;
  bit seen;
  logic pb, pl;
  logic [31:0] acc, e, d, w;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // Decode the serial stream: sample at BCLK rise, a frame ends on the sample where LRCLK drops
  always @(negedge clk) begin
    if (!mon) begin
      per = 0; nfr = 0; hi = 0; seen = 0; pb = bclk; pl = lrclk; acc = 0;
    end else begin
      per++;
      if (bclk && !pb) begin
        if (seen) check("bclk_period", per, 32);
        seen = 1;
        per = 0;
        acc = {acc[30:0], dout};
        if (pl && !lrclk) begin
          e = q.size() > 0 ? q.pop_front() : 32'd0;
          check("lrclk_high", hi, 16);
          check("frame", acc, e);
          nfr++;
          hi = 0;
        end
        if (lrclk) hi++;
        pl = lrclk;
      end
      pb = bclk;
    end
  end
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    avl.cs = 1; avl.write = 1; avl.addr = a; avl.writedata = v;
    @(posedge clk); #1;
    avl.cs = 0; avl.write = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    avl.cs = 1; avl.read = 1; avl.addr = a;
    @(posedge clk); #1;
    avl.cs = 0; avl.read = 0;
    v = avl.readdata;
  endtask
  task automatic run_frames(input int n);
    int c = 0;
    while (nfr < n && c < 1100 * n + 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("frames", nfr, n);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    avl.cs = 0; avl.read = 0; avl.write = 0; avl.addr = 0; avl.writedata = 0;
    idle(3);
    rst = 0;
    check("rst_out", {28'd0, irq, bclk, lrclk, dout}, 0);
    check("rst_rdata", avl.readdata, 0);
    rd(1, d); check("rst_status", d, 32'h0001_0000);
    mon = 1;
    wr(2, 1);
    run_frames(2);
    mon = 0;
    wr(2, 0);
    idle(3);
    rd(1, d); check("undr_status", d, 32'h0005_0000);
    wr(1, 32'h0004_0000);
    rd(1, d); check("undr_w1c", d, 32'h0001_0000);
    q.delete();
    q.push_back(32'hA5A5_3C3C);
    wr(0, 32'hA5A5_3C3C);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      q.push_back(w);
      wr(0, w);
    end
    rd(1, d); check("level4", d, 32'(q.size()));
    mon = 1;
    wr(2, 1);
    run_frames(6);
    mon = 0;
    wr(2, 0);
    idle(3);
    rd(1, d); check("drained", d, 32'h0005_0000);
    wr(1, 32'h0004_0000);
    q.delete();
    for (int i = 0; i < 257; i++) begin
      w = $urandom;
      wr(0, w);
      if (q.size() < 256) q.push_back(w);
    end
    rd(1, d); check("full_ovf", d, 32'h000A_0000 | 32'(q.size()));
    wr(2, 6);
    q.delete();
    idle(2);
    check("irq_empty", irq, 1);
    rd(1, d); check("flush_full", d, 32'h0009_0000);
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      q.push_back(w);
      wr(0, w);
    end
    idle(2);
    check("irq_128", irq, 0);
    rd(1, d); check("level128", d, 32'h0008_0080);
    mon = 1;
    wr(2, 5);
    check("irq_en0", irq, 0);
    idle(1);
    check("irq_pop", irq, 0);
    idle(1);
    check("irq_127", irq, 1);
    run_frames(3);
    mon = 0;
    wr(2, 4);
    idle(3);
    rd(1, d); check("level_run", d, 32'h0008_0000 | 32'(q.size() - 1));
    wr(1, 32'h000C_0000);
    rd(1, d); check("w1c_both", d, 32'(q.size() - 1));
    wr(2, 6);
    rd(1, d); check("flush_empty", d, 32'h0001_0000);
    q.delete();
    for (int i = 0; i < 10; i++) wr(0, $urandom);
    rd(1, d); check("level10", d, 32'd10);
    wr(2, 2);
    rd(1, d); check("flush10", d, 32'h0001_0000);
    w = $urandom;
    q.push_back(w);
    wr(0, w);
    mon = 1;
    wr(2, 5);
    run_frames(1);
    for (int c = 0; c < 40 && !bclk; c++) idle(1);
    check("pre_rst", {30'd0, bclk, irq}, 3);
    mon = 0;
    #3 rst = 1;
    #1 check("mid_rst", {28'd0, irq, bclk, lrclk, dout}, 0);
    idle(2);
    rst = 0;
    rd(1, d); check("rst_status2", d, 32'h0001_0000);
    rd(2, d); check("rst_ctrl", d, 0);
    wr(2, 7);
    rd(2, d); check("ctrl_rd", d, 32'h5);
    idle(1);
    check("rd_idle", avl.readdata, 0);
    rd(0, d); check("data_rd", d, 0);
    wr(3, $urandom);
    rd(3, d); check("addr3_rd", d, 0);
    rd(1, d); check("run_status", d, 32'h0015_0000);
    wr(2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
